// File: rtl/servant_spi_pkg.sv
// Shared types and constants for the servant SPI-RAM two-port arbiter.
package servant_spi_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusy    = 2'd1,
    StRelease = 2'd2
  } state_e;

  localparam logic PortA = 1'b0;
  localparam logic PortB = 1'b1;

  localparam logic [31:0] TimeoutData = 32'hDEAD_BEEF;

endpackage

// File: rtl/servant_spi_rr_arb2.sv
// Two-requester round-robin grant logic; owner register remembers the last winner.
module servant_spi_rr_arb2
  import servant_spi_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic en_i,
  output logic gnt_valid_o,
  output logic gnt_idx_o,
  output logic owner_o
);

  logic owner_q, owner_d;

  always_comb begin
    gnt_valid_o = en_i & (req_a_i | req_b_i);
    if (req_a_i && req_b_i) begin
      gnt_idx_o = ~owner_q;
    end else if (req_b_i) begin
      gnt_idx_o = PortB;
    end else begin
      gnt_idx_o = PortA;
    end
    owner_d = gnt_valid_o ? gnt_idx_o : owner_q;
  end

  // Reset owner is B so that port A wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q <= PortB;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign owner_o = owner_q;

endmodule

// File: rtl/servant_spi_arbiter.sv
// Two-port Wishbone arbiter sharing one SPI-RAM master between ports A and B.
// Define SERVANT_SPI_ARB_TIMEOUT_EN to add a slave-ack timeout with sticky o_timeout.
module servant_spi_arbiter
  import servant_spi_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic [AW-1:0] i_a_adr,
  input  logic [31:0]   i_a_dat,
  input  logic [3:0]    i_a_sel,
  input  logic          i_a_we,
  input  logic          i_a_cyc,
  output logic [31:0]   o_a_rdt,
  output logic          o_a_ack,
  input  logic [AW-1:0] i_b_adr,
  input  logic [31:0]   i_b_dat,
  input  logic [3:0]    i_b_sel,
  input  logic          i_b_we,
  input  logic          i_b_cyc,
  output logic [31:0]   o_b_rdt,
  output logic          o_b_ack,
  output logic [AW-1:0] o_s_adr,
  output logic [31:0]   o_s_dat,
  output logic [3:0]    o_s_sel,
  output logic          o_s_we,
  output logic          o_s_cyc,
  input  logic [31:0]   i_s_rdt,
  input  logic          i_s_ack,
`ifdef SERVANT_SPI_ARB_TIMEOUT_EN
  output logic          o_timeout,
`endif
  output logic          o_owner
);

  state_e        state_q, state_d;
  logic [AW-1:0] s_adr_q, s_adr_d;
  logic [31:0]   s_dat_q, s_dat_d;
  logic [3:0]    s_sel_q, s_sel_d;
  logic          s_we_q, s_we_d, s_cyc_q, s_cyc_d;
  logic [31:0]   a_rdt_q, a_rdt_d, b_rdt_q, b_rdt_d;
  logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic          abandon_q, abandon_d;
  logic          arb_en, gnt_valid, gnt_idx, owner_cyc, done;
  logic [31:0]   done_rdt;

`ifdef SERVANT_SPI_ARB_TIMEOUT_EN
  localparam int unsigned      CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  assign o_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, TimeoutData};
`endif

  assign arb_en = (state_q == StIdle);

  servant_spi_rr_arb2 u_rr_arb2 (
    .clk_i       (wb_clk),
    .rst_ni      (wb_rst_n),
    .req_a_i     (i_a_cyc),
    .req_b_i     (i_b_cyc),
    .en_i        (arb_en),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .owner_o     (o_owner)
  );

  always_comb begin
    state_d   = state_q;
    s_adr_d   = s_adr_q;
    s_dat_d   = s_dat_q;
    s_sel_d   = s_sel_q;
    s_we_d    = s_we_q;
    s_cyc_d   = s_cyc_q;
    a_rdt_d   = a_rdt_q;
    b_rdt_d   = b_rdt_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    abandon_d = abandon_q;
    done      = 1'b0;
    done_rdt  = i_s_rdt;
    owner_cyc = (o_owner == PortB) ? i_b_cyc : i_a_cyc;
`ifdef SERVANT_SPI_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          s_adr_d   = (gnt_idx == PortB) ? i_b_adr : i_a_adr;
          s_dat_d   = (gnt_idx == PortB) ? i_b_dat : i_a_dat;
          s_sel_d   = (gnt_idx == PortB) ? i_b_sel : i_a_sel;
          s_we_d    = (gnt_idx == PortB) ? i_b_we : i_a_we;
          s_cyc_d   = 1'b1;
          abandon_d = 1'b0;
          state_d   = StBusy;
`ifdef SERVANT_SPI_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      StBusy: begin
        // The SPI transfer cannot be aborted; a dropped owner only loses its ack.
        if (!owner_cyc) abandon_d = 1'b1;
        if (i_s_ack) begin
          done = 1'b1;
`ifdef SERVANT_SPI_ARB_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          done      = 1'b1;
          done_rdt  = TimeoutData;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
        if (done) begin
          s_cyc_d = 1'b0;
          state_d = StRelease;
          if (!abandon_d) begin
            if (o_owner == PortB) begin
              b_ack_d = 1'b1;
              b_rdt_d = done_rdt;
            end else begin
              a_ack_d = 1'b1;
              a_rdt_d = done_rdt;
            end
          end
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= StIdle;
      s_adr_q   <= '0;
      s_dat_q   <= '0;
      s_sel_q   <= '0;
      s_we_q    <= 1'b0;
      s_cyc_q   <= 1'b0;
      a_rdt_q   <= '0;
      b_rdt_q   <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      abandon_q <= 1'b0;
`ifdef SERVANT_SPI_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_adr_q   <= s_adr_d;
      s_dat_q   <= s_dat_d;
      s_sel_q   <= s_sel_d;
      s_we_q    <= s_we_d;
      s_cyc_q   <= s_cyc_d;
      a_rdt_q   <= a_rdt_d;
      b_rdt_q   <= b_rdt_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      abandon_q <= abandon_d;
`ifdef SERVANT_SPI_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign o_s_adr = s_adr_q;
  assign o_s_dat = s_dat_q;
  assign o_s_sel = s_sel_q;
  assign o_s_we  = s_we_q;
  assign o_s_cyc = s_cyc_q;
  assign o_a_rdt = a_rdt_q;
  assign o_b_rdt = b_rdt_q;
  assign o_a_ack = a_ack_q;
  assign o_b_ack = b_ack_q;

endmodule

// File: tb/tb_servant_spi_arbiter.sv
// Self-checking bench for servant_spi_arbiter: directed vector table, hand-written
// reset/timeout sequences and randomized traffic against a transaction-level model.
module tb_servant_spi_arbiter;

  localparam int unsigned AW = 32;

  logic          wb_clk = 1'b0;
  logic          wb_rst_n;
  logic [AW-1:0] i_a_adr, i_b_adr, o_s_adr;
  logic [31:0]   i_a_dat, i_b_dat, o_a_rdt, o_b_rdt, o_s_dat, i_s_rdt;
  logic [3:0]    i_a_sel, i_b_sel, o_s_sel;
  logic          i_a_we, i_a_cyc, o_a_ack, i_b_we, i_b_cyc, o_b_ack;
  logic          o_s_we, o_s_cyc, i_s_ack, o_owner;
`ifdef SERVANT_SPI_ARB_TIMEOUT_EN
  logic          o_timeout;
`endif

  servant_spi_arbiter #(
    .AW             (AW),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .wb_clk    (wb_clk),
    .wb_rst_n  (wb_rst_n),
    .i_a_adr   (i_a_adr),
    .i_a_dat   (i_a_dat),
    .i_a_sel   (i_a_sel),
    .i_a_we    (i_a_we),
    .i_a_cyc   (i_a_cyc),
    .o_a_rdt   (o_a_rdt),
    .o_a_ack   (o_a_ack),
    .i_b_adr   (i_b_adr),
    .i_b_dat   (i_b_dat),
    .i_b_sel   (i_b_sel),
    .i_b_we    (i_b_we),
    .i_b_cyc   (i_b_cyc),
    .o_b_rdt   (o_b_rdt),
    .o_b_ack   (o_b_ack),
    .o_s_adr   (o_s_adr),
    .o_s_dat   (o_s_dat),
    .o_s_sel   (o_s_sel),
    .o_s_we    (o_s_we),
    .o_s_cyc   (o_s_cyc),
    .i_s_rdt   (i_s_rdt),
    .i_s_ack   (i_s_ack),
`ifdef SERVANT_SPI_ARB_TIMEOUT_EN
    .o_timeout (o_timeout),
`endif
    .o_owner   (o_owner)
  );

  always #5 wb_clk = ~wb_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending requests per port, last winner, last data returned per port.
  logic        p_req[2];
  logic [31:0] p_adr[2], p_dat[2];
  logic [3:0]  p_sel[2];
  logic        p_we[2];
  logic        m_last;
  logic [31:0] m_rdt[2];

  typedef struct {
    bit          rst;
    bit          new_a;
    bit          new_b;
    logic [31:0] a_adr, a_dat;
    logic [3:0]  a_sel;
    logic        a_we;
    logic [31:0] b_adr, b_dat;
    logic [3:0]  b_sel;
    logic        b_we;
    int          lat;
    logic [31:0] rdata;
    int          drop_at;
    logic        exp_own;
    logic [31:0] exp_adr, exp_dat;
    logic [3:0]  exp_sel;
    logic        exp_we;
    logic        exp_ack;
  } vec_t;

  vec_t tbl[8];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic raise(input int p, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
    p_req[p] = 1'b1;
    p_adr[p] = adr;
    p_dat[p] = dat;
    p_sel[p] = sel;
    p_we[p]  = we;
  endtask

  task automatic apply_ports();
    i_a_cyc = p_req[0]; i_a_adr = p_adr[0]; i_a_dat = p_dat[0];
    i_a_sel = p_sel[0]; i_a_we  = p_we[0];
    i_b_cyc = p_req[1]; i_b_adr = p_adr[1]; i_b_dat = p_dat[1];
    i_b_sel = p_sel[1]; i_b_we  = p_we[1];
  endtask

  task automatic do_reset();
    wb_rst_n = 1'b0;
    i_s_ack  = 1'b0;
    i_s_rdt  = '0;
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 1'b0; p_adr[p] = '0; p_dat[p] = '0; p_sel[p] = '0; p_we[p] = 1'b0;
      m_rdt[p] = '0;
    end
    m_last = 1'b1;
    apply_ports();
    repeat (2) @(negedge wb_clk);
    check1("rst_s_cyc", o_s_cyc, 1'b0);
    check32("rst_s_adr", o_s_adr, 32'h0);
    check32("rst_s_dat", o_s_dat, 32'h0);
    check32("rst_s_sel", {28'h0, o_s_sel}, 32'h0);
    check1("rst_s_we", o_s_we, 1'b0);
    check1("rst_a_ack", o_a_ack, 1'b0);
    check1("rst_b_ack", o_b_ack, 1'b0);
    check32("rst_a_rdt", o_a_rdt, 32'h0);
    check32("rst_b_rdt", o_b_rdt, 32'h0);
    check1("rst_owner", o_owner, 1'b1);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
  endtask

  // Called at a negedge in IDLE with requests driven. Returns at a negedge in IDLE.
  task automatic xfer(input string tag, input int lat, input logic [31:0] data,
                      input int drop_at, input logic own, input logic [31:0] e_adr,
                      input logic [31:0] e_dat, input logic [3:0] e_sel, input logic e_we,
                      input logic e_ack);
    bit stable;
    @(negedge wb_clk);
    check1({tag, "_grant"}, o_s_cyc, 1'b1);
    check1({tag, "_owner"}, o_owner, own);
    check32({tag, "_adr"}, o_s_adr, e_adr);
    check32({tag, "_dat"}, o_s_dat, e_dat);
    check32({tag, "_sel"}, {28'h0, o_s_sel}, {28'h0, e_sel});
    check1({tag, "_we"}, o_s_we, e_we);
    stable = 1'b1;
    for (int c = 0; c < lat; c++) begin
      if (own) begin
        i_b_adr = $urandom; i_b_dat = $urandom; i_b_sel = 4'($urandom); i_b_we = 1'($urandom);
      end else begin
        i_a_adr = $urandom; i_a_dat = $urandom; i_a_sel = 4'($urandom); i_a_we = 1'($urandom);
      end
      if (c == drop_at) begin
        p_req[own] = 1'b0;
        if (own) i_b_cyc = 1'b0; else i_a_cyc = 1'b0;
      end
      @(negedge wb_clk);
      if (o_s_cyc !== 1'b1 || o_s_adr !== e_adr || o_s_dat !== e_dat ||
          o_s_sel !== e_sel || o_s_we !== e_we || o_a_ack !== 1'b0 || o_b_ack !== 1'b0)
        stable = 1'b0;
    end
    check1({tag, "_hold"}, stable, 1'b1);
    i_s_ack = 1'b1;
    i_s_rdt = data;
    @(negedge wb_clk);
    p_req[own] = 1'b0;
    if (own) i_b_cyc = 1'b0; else i_a_cyc = 1'b0;
    if (e_ack) m_rdt[own] = data;
    check1({tag, "_ack_own"}, own ? o_b_ack : o_a_ack, e_ack);
    check1({tag, "_ack_other"}, own ? o_a_ack : o_b_ack, 1'b0);
    check32({tag, "_rdt_a"}, o_a_rdt, m_rdt[0]);
    check32({tag, "_rdt_b"}, o_b_rdt, m_rdt[1]);
    check1({tag, "_cyc_drop"}, o_s_cyc, 1'b0);
    // Slave ack left high through RELEASE must be ignored.
    i_s_rdt = $urandom;
    @(negedge wb_clk);
    i_s_ack = 1'b0;
    check1({tag, "_pulse_a"}, o_a_ack, 1'b0);
    check1({tag, "_pulse_b"}, o_b_ack, 1'b0);
    check1({tag, "_release"}, o_s_cyc, 1'b0);
    check32({tag, "_keep_a"}, o_a_rdt, m_rdt[0]);
    check32({tag, "_keep_b"}, o_b_rdt, m_rdt[1]);
    m_last = own;
  endtask

  initial begin
    wb_rst_n = 1'b0;
    do_reset();

    // Slave ack while idle.
    i_s_ack = 1'b1;
    i_s_rdt = 32'hFFFF_0000;
    @(negedge wb_clk);
    check1("idle_ack_a", o_a_ack, 1'b0);
    check1("idle_ack_b", o_b_ack, 1'b0);
    check1("idle_cyc", o_s_cyc, 1'b0);
    check32("idle_rdt_a", o_a_rdt, 32'h0);
    i_s_ack = 1'b0;
    @(negedge wb_clk);

    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0,
               2000, 32'h1234_5678, -1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h200, 32'h1111_1111, 4'hF, 1'b0,
               32'h300, 32'h2222_2222, 4'hF, 1'b1,
               5, 32'hAAAA_0001, -1, 1'b0, 32'h200, 32'h1111_1111, 4'hF, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0,
               7, 32'hBBBB_0002, -1, 1'b1, 32'h300, 32'h2222_2222, 4'hF, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h400, 32'h3333_3333, 4'h1, 1'b0,
               32'h500, 32'h4444_4444, 4'h2, 1'b1,
               3, 32'hCCCC_0003, -1, 1'b0, 32'h400, 32'h3333_3333, 4'h1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0,
               0, 32'hDDDD_0004, -1, 1'b1, 32'h500, 32'h4444_4444, 4'h2, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 32'h600, 32'hCAFE_F00D, 4'h3, 1'b1,
               30, 32'h0, -1, 1'b1, 32'h600, 32'hCAFE_F00D, 4'h3, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h700, 32'h0, 4'hF, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0,
               40, 32'hEEEE_0006, 10, 1'b0, 32'h700, 32'h0, 4'hF, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h800, 32'h5555_5555, 4'h8, 1'b1,
               32'h0, 32'h0, 4'h0, 1'b0,
               0, 32'h5A5A_5A5A, -1, 1'b0, 32'h800, 32'h5555_5555, 4'h8, 1'b1, 1'b1};

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rst) do_reset();
      if (tbl[i].new_a) raise(0, tbl[i].a_adr, tbl[i].a_dat, tbl[i].a_sel, tbl[i].a_we);
      if (tbl[i].new_b) raise(1, tbl[i].b_adr, tbl[i].b_dat, tbl[i].b_sel, tbl[i].b_we);
      apply_ports();
      xfer($sformatf("tbl%0d", i), tbl[i].lat, tbl[i].rdata, tbl[i].drop_at, tbl[i].exp_own,
           tbl[i].exp_adr, tbl[i].exp_dat, tbl[i].exp_sel, tbl[i].exp_we, tbl[i].exp_ack);
    end

    // Asynchronous reset in the middle of a transfer.
    raise(0, 32'h900, 32'h9, 4'hF, 1'b1);
    apply_ports();
    @(negedge wb_clk);
    check1("mid_grant", o_s_cyc, 1'b1);
    repeat (5) @(negedge wb_clk);
    #2 wb_rst_n = 1'b0;
    #1;
    check1("async_s_cyc", o_s_cyc, 1'b0);
    check1("async_ack_a", o_a_ack, 1'b0);
    check1("async_ack_b", o_b_ack, 1'b0);
    check1("async_owner", o_owner, 1'b1);
    check32("async_s_adr", o_s_adr, 32'h0);
    do_reset();
    raise(0, 32'hA00, 32'h0A0A_0A0A, 4'hC, 1'b0);
    apply_ports();
    xfer("post_rst", 4, 32'h0BAD_F00D, -1, 1'b0, 32'hA00, 32'h0A0A_0A0A, 4'hC, 1'b0, 1'b1);

    // Randomized traffic against the transaction-level model.
    for (int it = 0; it < 40; it++) begin
      logic win;
      int   lat, drop;
      for (int p = 0; p < 2; p++)
        if (!p_req[p] && $urandom_range(0, 1) == 1)
          raise(p, $urandom, $urandom, 4'($urandom), 1'($urandom));
      if (!p_req[0] && !p_req[1])
        raise(int'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), 1'($urandom));
      apply_ports();
      win  = (p_req[0] && p_req[1]) ? ~m_last : p_req[1];
      lat  = int'($urandom_range(0, 20));
      drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 25)) : -1;
      xfer($sformatf("rnd%0d", it), lat, $urandom, drop, win, p_adr[win], p_dat[win],
           p_sel[win], p_we[win], !(drop >= 0 && drop < lat));
    end

`ifdef SERVANT_SPI_ARB_TIMEOUT_EN
    begin
      int k;
      do_reset();
      raise(0, 32'hB00, 32'h0, 4'hF, 1'b0);
      apply_ports();
      @(negedge wb_clk);
      check1("to_grant", o_s_cyc, 1'b1);
      k = 0;
      while (o_a_ack !== 1'b1 && k < 200) begin
        @(negedge wb_clk);
        k++;
      end
      check32("to_cycles", k, 32'd64);
      check32("to_rdt", o_a_rdt, 32'hDEAD_BEEF);
      check1("to_flag", o_timeout, 1'b1);
      check1("to_cyc_drop", o_s_cyc, 1'b0);
      p_req[0] = 1'b0;
      apply_ports();
      repeat (3) @(negedge wb_clk);
      check1("to_sticky", o_timeout, 1'b1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/servant_spi_arbiter.md
Name: servant_spi_arbiter

Overview:
- Two-port Wishbone arbiter that shares the single SPI-RAM master interface between the CPU memory bus (port A) and a second requester (port B, e.g. a boot loader or debug DMA).
- Sits between the CPU/loader buses and the SPI master bridge.
- Latches each granted request, holds it stable for the multi-thousand-cycle SPI transfer, returns the ack to the owner only, and round-robins on contention.

Parameters:
- AW, 32, address width on all ports.
- TIMEOUT_CYCLES, 4096, maximum cycles a granted transfer may wait for slave ack (used only with the optional feature).

Ports:
- wb_clk  in  1  system clock
- wb_rst_n  in  1  asynchronous active-low reset
- i_a_adr  in  AW  port A address
- i_a_dat  in  32  port A write data
- i_a_sel  in  4  port A byte select
- i_a_we  in  1  port A write enable
- i_a_cyc  in  1  port A request (cyc/stb combined)
- o_a_rdt  out  32  port A read data
- o_a_ack  out  1  port A ack, one-cycle pulse
- i_b_adr, i_b_dat, i_b_sel, i_b_we, i_b_cyc, o_b_rdt, o_b_ack: same as port A, for port B
- o_s_adr  out  AW  to SPI master address
- o_s_dat  out  32  to SPI master write data
- o_s_sel  out  4  to SPI master byte select
- o_s_we  out  1  to SPI master write enable
- o_s_cyc  out  1  to SPI master request
- i_s_rdt  in  32  from SPI master read data
- i_s_ack  in  1  from SPI master ack
- o_owner  out  1  current or last owner (0=A, 1=B)

Behaviour:
- Interface (decided): one clock, wb_clk; reset wb_rst_n is asynchronous and active-low.
- Reset values: state IDLE; o_s_cyc=0; o_s_adr/dat/sel/we=0; o_a_ack=o_b_ack=0; o_a_rdt=o_b_rdt=0; o_owner=1, so port A wins the first tie.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - Sample i_a_cyc and i_b_cyc.
  - Only one requesting: grant it.
  - Both requesting: grant the port that is not o_owner (round-robin).
  - On grant, register the winner's adr/dat/sel/we into the o_s_* registers, set o_owner, go to BUSY. o_s_cyc rises in the cycle after the request is first seen (1-cycle grant latency).
- BUSY:
  - o_s_cyc=1; o_s_* held constant regardless of master activity.
  - On i_s_ack: register i_s_rdt into the owner's rdt, pulse the owner's ack for exactly one cycle (the cycle after i_s_ack), drop o_s_cyc, go to RELEASE.
- RELEASE:
  - One cycle with o_s_cyc=0. This lets the CPU deassert cyc after ack so a stale request is not re-granted.
  - Then return to IDLE.
- Owner rdt stays valid until the next ack to that port. The non-owner's ack stays 0 and its rdt is unchanged.
- Owner drops cyc while BUSY: the transfer still completes (SPI cannot abort); the ack is suppressed and the data is discarded.
- New requests during BUSY/RELEASE wait; they are evaluated in IDLE.
- i_s_ack outside BUSY is ignored.
- Back-to-back requests by the same port with the other idle: served consecutively. Minimum request-to-request spacing is 3 cycles plus the slave latency.
- Async reset mid-transfer: all outputs return to reset values immediately; the SPI master is reset by the same reset.

Optional Feature:
- Macro: SERVANT_SPI_ARB_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entering BUSY and increments each BUSY cycle.
  - On reaching TIMEOUT_CYCLES without i_s_ack: drop o_s_cyc, pulse the owner's ack with rdt=32'hDEAD_BEEF, set a sticky output o_timeout (1 bit, reset 0, cleared only by reset), go to RELEASE.
  - i_s_ack in the same cycle as timeout: ack wins, normal data is returned.
- Undefined: no counter and no o_timeout port; BUSY waits indefinitely.

Decomposition:
- Shared package servant_spi_pkg:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2).
  - Port index constants PORT_A=1'b0, PORT_B=1'b1.
  - Timeout data constant 32'hDEAD_BEEF.
- Natural sub-module: servant_spi_rr_arb2, the two-requester round-robin grant logic with an owner register.

Test Plan:
- Single read on A, adr=0x100, slave acks after 2000 cycles with 0x12345678 -> o_s_cyc high 1 cycle after i_a_cyc; o_a_rdt=0x12345678, o_a_ack one pulse; o_b_ack stays 0.
- A and B both request from IDLE after reset -> A granted first; after A's ack plus RELEASE, B granted; next tie goes to A.
- Write on B, dat=0xCAFEF00D, sel=4'b0011; B changes adr/dat mid-BUSY -> o_s_adr/dat/sel unchanged until ack.
- A drops cyc 10 cycles into BUSY -> o_s_cyc stays high until i_s_ack; no o_a_ack; FSM passes through RELEASE to IDLE.
- wb_rst_n asserted mid-BUSY -> o_s_cyc and both acks 0 asynchronously; after release, first transfer behaves normally.
- With SERVANT_SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64, slave never acks -> owner ack at BUSY cycle 64 with rdt=0xDEADBEEF; o_timeout=1 and sticky.
